// File: rtl/latency_fifo_if.sv
// latency_fifo_if: request credit, result return and drain handshake of latency_fifo.
interface latency_fifo_if #(parameter int WIDTH = 16);
   logic             req_ready;
   logic             req_valid;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             err;
   modport master (input req_ready, out_valid, out_data, err,
                   output req_valid, rsp_valid, rsp_data, out_ready);
   modport slave (output req_ready, out_valid, out_data, err,
                  input req_valid, rsp_valid, rsp_data, out_ready);
endinterface

// File: rtl/latency_fifo.sv
// latency_fifo: credit-managed return buffer for a fixed-latency path, drained by valid/ready.
module latency_fifo #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input logic           clk,
   input logic           reset,
   latency_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1) begin : g_bad_params
      $error("latency_fifo: DEPTH must be a power of two >= 2 and LATENCY >= 1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count, inflight;
   logic             issue, pop, push, full, under;

   // Credits cover stored plus in-flight results, so a return always finds a slot.
   always_comb begin
      full          = count == FULL;
      bus.req_ready = !reset && ({1'b0, count} + {1'b0, inflight} < {1'b0, FULL});
      bus.out_valid = !reset && count != '0;
      bus.out_data  = mem[rd_ptr];
      issue         = bus.req_valid && bus.req_ready;
      pop           = bus.out_valid && bus.out_ready;
      push          = bus.rsp_valid && (!full || pop);
      under         = bus.rsp_valid && inflight == '0 && !issue;
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.rsp_data;

   always_ff @(posedge clk)
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         bus.err  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (!under) inflight <= inflight + CW'(issue) - CW'(bus.rsp_valid);
         if (under || (bus.rsp_valid && full && !pop) || (bus.req_valid && !bus.req_ready))
            bus.err <= 1'b1;
      end
endmodule

// File: tb/tb_latency_fifo.sv
// tb_latency_fifo: directed checks of latency_fifo fed by a two-stage delay path model.
module tb_latency_fifo;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   latency_fifo_if #(.WIDTH(16)) b ();
   latency_fifo #(.WIDTH(16), .LATENCY(2), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(b));

   // Delay path of DELAY=2 returning the issue index as data, plus an injection port.
   logic [1:0]  dv;
   logic [15:0] dd [2];
   logic [15:0] idx;
   logic        inj_v = 1'b0;
   logic [15:0] inj_d = '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         dv  <= '0;
         idx <= '0;
      end else begin
         dv <= {dv[0], b.req_valid && b.req_ready};
         if (b.req_valid && b.req_ready) idx <= idx + 16'd1;
      end
      dd[0] <= idx;
      dd[1] <= dd[0];
   end
   assign b.rsp_valid = dv[1] | inj_v;
   assign b.rsp_data  = inj_v ? inj_d : dd[1];

   int total = 0;
   int bad = 0;
   logic [15:0] exp7 [4] = '{16'd1, 16'd2, 16'd3, 16'hCAFE};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The requester only raises req_valid when a credit is offered.
   task automatic drive(input logic want, input logic ordy);
      b.req_valid = want && b.req_ready;
      b.out_ready = ordy;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      b.req_valid = 1'b0;
      b.out_ready = 1'b0;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      b.req_valid = 1'b0;
      b.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_req_ready", b.req_ready, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_req_ready", b.req_ready, 1);
      chk("post_rst_err", b.err, 0);
      chk("post_rst_out_valid", b.out_valid, 0);

      // Streaming at full rate: output starts three cycles after the first issue.
      for (int c = 0; c < 12; c++) begin
         drive(1'b1, 1'b1);
         chk("t1_req_ready", b.req_ready, 1);
         if (c >= 3) begin
            chk("t1_out_valid", b.out_valid, 1);
            chk("t1_out_data", b.out_data, c - 3);
         end else chk("t1_out_valid_early", b.out_valid, 0);
         tick();
      end
      drive(1'b0, 1'b1);
      repeat (4) tick();
      chk("t1_drained", b.out_valid, 0);
      chk("t1_err", b.err, 0);

      // Stalled consumer: credits run out after four issues.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 1'b0);
         chk("t2_req_ready", b.req_ready, c < 4);
         tick();
      end
      chk("t2_issues", idx, 4);
      chk("t2_count", dut.count, 4);
      chk("t2_inflight", dut.inflight, 0);
      chk("t2_err", b.err, 0);

      // One pop frees one credit; the new result queues behind 1,2,3.
      drive(1'b1, 1'b1);
      chk("t3_pop_valid", b.out_valid, 1);
      chk("t3_pop_data", b.out_data, 0);
      tick();
      drive(1'b1, 1'b0);
      chk("t3_credit", b.req_ready, 1);
      tick();
      drive(1'b0, 1'b0);
      repeat (4) tick();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b1);
         chk("t3_valid", b.out_valid, 1);
         chk("t3_data", b.out_data, k);
         tick();
      end
      chk("t3_empty", b.out_valid, 0);
      chk("t3_err", b.err, 0);

      // Stray return with nothing in flight.
      drive(1'b0, 1'b0);
      inj_d = 16'h0055;
      inj_v = 1'b1;
      tick();
      inj_v = 1'b0;
      chk("t4_err", b.err, 1);
      chk("t4_inflight", dut.inflight, 0);
      chk("t4_count", dut.count, 1);
      chk("t4_data", b.out_data, 16'h0055);
      drive(1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0);
      repeat (3) tick();
      chk("t4_err_sticky", b.err, 1);
      chk("t4_empty", b.out_valid, 0);

      // Overflow into a full FIFO is dropped.
      do_reset();
      chk("t5_err_cleared", b.err, 0);
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 1'b0);
         tick();
      end
      chk("t5_count", dut.count, 4);
      drive(1'b0, 1'b0);
      inj_d = 16'hBEEF;
      inj_v = 1'b1;
      tick();
      inj_v = 1'b0;
      chk("t5_err", b.err, 1);
      chk("t5_count_kept", dut.count, 4);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1);
         chk("t5_valid", b.out_valid, 1);
         chk("t5_data", b.out_data, k);
         tick();
      end
      drive(1'b0, 1'b0);
      tick();
      chk("t5_no_beef", b.out_valid, 0);

      // Full with simultaneous pop and return: the return is kept.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 1'b1);
      inj_d = 16'hCAFE;
      inj_v = 1'b1;
      chk("t7_pop_data", b.out_data, 0);
      tick();
      inj_v = 1'b0;
      chk("t7_count", dut.count, 4);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1);
         chk("t7_data", b.out_data, exp7[k]);
         tick();
      end
      chk("t7_empty", b.out_valid, 0);
      chk("t7_err", b.err, 1);

      // Reset with two stored and two in flight discards everything.
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0);
         tick();
      end
      chk("t6_count", dut.count, 2);
      chk("t6_inflight", dut.inflight, 2);
      reset = 1'b1;
      b.req_valid = 1'b0;
      #1;
      chk("t6_rst_out_valid", b.out_valid, 0);
      chk("t6_rst_req_ready", b.req_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("t6_out_valid", b.out_valid, 0);
      chk("t6_req_ready", b.req_ready, 1);
      chk("t6_err", b.err, 0);
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b1);
         tick();
         chk("t6_no_stale", b.out_valid, 0);
      end
      chk("t6_err_after", b.err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
